// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB low/full-speed transmitter: SYNC, bit-stuffed NRZI data, EOP
// Ports:
//   reset  : asynchronous active-high reset
//   clk    : system clock
//   clk_en : bit-rate strobe, one clk per bit time
//   data   : byte from the SIE, loaded at each load point
//   valid  : SIE has a byte / packet-start request
//   ready  : one-clk pulse after data was loaded
//   txd    : line state (J, K, SE0)
//   oe     : transceiver drive enable
//   active : high from the first SYNC bit through the EOP J bit
package types;
  typedef enum logic [1:0] {SE0 = 2'b00, K = 2'b01, J = 2'b10, SE1 = 2'b11} d_port_t;
endpackage

module usb_tx
  import types::*;
#(
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       reset,
  input  logic       clk,
  input  logic       clk_en,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output d_port_t    txd,
  output logic       oe,
  output logic       active
);

  localparam int EOP_W = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [EOP_W-1:0] EOP_LAST = EOP_W'(EOP_SE0_BITS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t           state, state_d;
  logic [2:0]       idx, idx_d;       // position of the bit on the line within SYNC or the byte
  logic [2:0]       ones, ones_d;     // consecutive ones transmitted, including the current bit
  logic [7:0]       shreg, shreg_d;
  logic             more, more_d;     // a byte was accepted at the most recent load point
  logic [EOP_W-1:0] eop_cnt, eop_d;
  d_port_t          txd_d;
  logic             oe_d, active_d, ready_d;
  logic             send, bit_val;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    ones_d   = ones;
    shreg_d  = shreg;
    more_d   = more;
    eop_d    = eop_cnt;
    txd_d    = txd;
    oe_d     = oe;
    active_d = active;
    ready_d  = 1'b0;
    send     = 1'b0;
    bit_val  = 1'b0;

    if (clk_en) begin
      case (state)
        IDLE: begin
          txd_d    = J;
          oe_d     = 1'b0;
          active_d = 1'b0;
          ones_d   = 3'd0;
          idx_d    = 3'd0;
          if (valid) begin
            state_d  = SYNC;
            oe_d     = 1'b1;
            active_d = 1'b1;
            send     = 1'b1;
            bit_val  = 1'b0;
          end
        end
        SYNC, DATA, STUFF: begin
          if (state != STUFF && ones == 3'd6) begin
            // stuff bit: forced 0, the pending data bit is not consumed
            state_d = STUFF;
            send    = 1'b1;
            bit_val = 1'b0;
          end else if (idx != 3'd7) begin
            state_d = (state == SYNC) ? SYNC : DATA;
            idx_d   = idx + 3'd1;
            send    = 1'b1;
            bit_val = (state == SYNC) ? (idx == 3'd6) : shreg[idx + 3'd1];
            // Load point: this edge drives the last bit of the unit. The old
            // shreg[7] is already captured in bit_val, so the register is free.
            if (idx == 3'd6) begin
              more_d = valid;
              if (valid) begin
                shreg_d = data;
                ready_d = 1'b1;
              end
            end
          end else if (more) begin
            state_d = DATA;
            idx_d   = 3'd0;
            send    = 1'b1;
            bit_val = shreg[0];
          end else begin
            state_d = EOP_SE0;
            txd_d   = SE0;
            eop_d   = '0;
          end
        end
        EOP_SE0: begin
          txd_d = SE0;
          if (eop_cnt == EOP_LAST) begin
            state_d = EOP_J;
            txd_d   = J;
          end else begin
            eop_d = eop_cnt + EOP_W'(1);
          end
        end
        EOP_J: begin
          state_d  = IDLE;
          txd_d    = J;
          oe_d     = 1'b0;
          active_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // NRZI: a 0 toggles the line and breaks the run of ones, a 1 holds it
      if (send) begin
        if (!bit_val) begin
          txd_d  = (txd == J) ? K : J;
          ones_d = 3'd0;
        end else begin
          ones_d = ones + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= 3'd0;
      ones    <= 3'd0;
      shreg   <= 8'd0;
      more    <= 1'b0;
      eop_cnt <= '0;
      txd     <= J;
      oe      <= 1'b0;
      active  <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      ones    <= ones_d;
      shreg   <= shreg_d;
      more    <= more_d;
      eop_cnt <= eop_d;
      txd     <= txd_d;
      oe      <= oe_d;
      active  <= active_d;
      ready   <= ready_d;
    end
  end

endmodule
